// File: rtl/dup_mode_alu_seq_if.sv
// Handshake bundle for dup_mode_alu_seq: operand side (in_*, mode, val1/val2)
// and result side (out_*, res, ovf). The slave modport is the ALU's view.
interface dup_mode_alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       mode;
  logic [WIDTH-1:0] val1;
  logic [WIDTH-1:0] val2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] res;
  logic             ovf;

  modport slave (
    input  in_valid, mode, val1, val2, out_ready,
    output in_ready, out_valid, res, ovf
  );

  modport master (
    output in_valid, mode, val1, val2, out_ready,
    input  in_ready, out_valid, res, ovf
  );
endinterface

// File: rtl/dup_mode_alu_seq.sv
// Handshaked mode-select compare/arithmetic unit with a WIDTH-cycle restoring divider.
// Optional build macro DUP_ALU_SAT_EN selects saturating instead of wrapping arithmetic.
module dup_mode_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  dup_mode_alu_seq_if.slave   bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_DIV  = 1'b1;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_res;
  logic             r_ovf;
  logic             r_out_valid;

  logic               w_in_ready;
  logic               w_accept;
  logic               w_is_div;
  logic               w_div_done;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_op_res;
  logic               w_op_ovf;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;

  // A result may drain and a new operation be accepted in the same cycle.
  assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_is_div   = (bus.mode == 3'b011) && !(bus.val1 < bus.val2);
  assign w_div_done = (r_state == S_DIV) && (r_cnt == '0);

  assign w_sum  = {1'b0, bus.val1} + {1'b0, bus.val2};
  assign w_diff = {1'b0, bus.val1} - {1'b0, bus.val2};
  assign w_prod = {{WIDTH{1'b0}}, bus.val1} * {{WIDTH{1'b0}}, bus.val2};

  always_comb begin
    w_op_res = bus.val1 ^ bus.val2;
    w_op_ovf = 1'b0;
    case (bus.mode)
      3'b001, 3'b010: begin
        if (bus.val1 > bus.val2) begin
          w_op_res = w_sum[WIDTH-1:0];
          w_op_ovf = w_sum[WIDTH];
`ifdef DUP_ALU_SAT_EN
          if (w_sum[WIDTH]) w_op_res = '1;
`endif
        end else begin
          w_op_res = w_diff[WIDTH-1:0];
          w_op_ovf = w_diff[WIDTH];
`ifdef DUP_ALU_SAT_EN
          if (w_diff[WIDTH]) w_op_res = '0;
`endif
        end
      end
      3'b011: begin
        // Divide branch is produced by the sequential divider, not here.
        w_op_res = w_prod[WIDTH-1:0];
        w_op_ovf = |w_prod[2*WIDTH-1:WIDTH];
`ifdef DUP_ALU_SAT_EN
        if (|w_prod[2*WIDTH-1:WIDTH]) w_op_res = '1;
`endif
      end
      3'b100: begin
        if (bus.val1 != bus.val2) begin
          w_op_res = (bus.val1 > bus.val2) ? bus.val1 : bus.val2;
          w_op_ovf = 1'b0;
        end else begin
          w_op_res = w_sum[WIDTH-1:0];
          w_op_ovf = w_sum[WIDTH];
`ifdef DUP_ALU_SAT_EN
          if (w_sum[WIDTH]) w_op_res = '1;
`endif
        end
      end
      default: begin
        w_op_res = bus.val1 ^ bus.val2;
        w_op_ovf = 1'b0;
      end
    endcase
  end

  // Restoring step: partial remainder stays below the divisor, so the
  // subtraction is exact in WIDTH bits whenever the trial fits.
  assign w_trial    = {r_rem, r_quo[WIDTH-1]};
  assign w_fits     = (w_trial >= {1'b0, r_dvs});
  assign w_rem_next = w_fits ? (w_trial[WIDTH-1:0] - r_dvs) : w_trial[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], w_fits};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_dvs       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept && w_is_div) begin
            r_state <= S_DIV;
            r_rem   <= '0;
            r_quo   <= bus.val1;
            r_dvs   <= (bus.val2 == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : bus.val2;
            r_cnt   <= WIDTH'(WIDTH - 1);
          end
        end
        S_DIV: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == '0) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_accept && !w_is_div) begin
        r_res       <= w_op_res;
        r_ovf       <= w_op_ovf;
        r_out_valid <= 1'b1;
      end else if (w_div_done) begin
        r_res       <= w_quo_next;
        r_ovf       <= 1'b0;
        r_out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.res       = r_res;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_dup_mode_alu_seq.sv
// Scoreboard bench for dup_mode_alu_seq: directed vectors push expected results,
// an independent monitor pops and compares on every output transfer.
module tb_dup_mode_alu_seq;
  localparam int W = 8;
`ifdef DUP_ALU_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  dup_mode_alu_seq_if #(.WIDTH(W)) bus ();

  dup_mode_alu_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;
  logic [W:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: compare every accepted result against the scoreboard head.
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      check($sformatf("result_expected#%0d", n_out), {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        $display("out #%0d: res=%0d ovf=%0d (expected res=%0d ovf=%0d)",
                 n_out, bus.res, bus.ovf, e[W-1:0], e[W]);
        check($sformatf("res#%0d", n_out), {24'd0, bus.res}, {24'd0, e[W-1:0]});
        check($sformatf("ovf#%0d", n_out), {31'd0, bus.ovf}, {31'd0, e[W]});
      end
    end
  end

  task automatic send(input logic [2:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] er, input logic eo, input bit push,
                      output int waited);
    bus.in_valid = 1'b1;
    bus.mode     = m;
    bus.val1     = a;
    bus.val2     = b;
    waited       = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) check("accept_timeout", {31'd0, bus.in_ready}, 32'd1);
    else if (push) exp_q.push_back({eo, er});
    $display("issue: mode=%0d val1=%0d val2=%0d waited=%0d", m, a, b, waited);
    @(posedge clk);
    #1;
    // Scramble the inputs after accept; captured operands must be unaffected.
    bus.in_valid = 1'b0;
    bus.mode     = 3'b001;
    bus.val1     = '1;
    bus.val2     = 8'd1;
  endtask

  task automatic wait_result(output int cycles, output bit rdy_seen);
    cycles   = 0;
    rdy_seen = 1'b0;
    while (!bus.out_valid && cycles < 40) begin
      if (bus.in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    int  wt;
    int  cyc;
    bit  rdy;
    int  seen;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.mode      = 3'b000;
    bus.val1      = '0;
    bus.val2      = '0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("reset_res", {24'd0, bus.res}, 32'd0);
    check("reset_ovf", {31'd0, bus.ovf}, 32'd0);

    // Add with carry, subtract with borrow, xor: back-to-back at full rate.
    send(3'b001, 8'd200, 8'd100, SAT ? 8'd255 : 8'd44, 1'b1, 1'b1, wt);
    check("lat1_add", {31'd0, bus.out_valid}, 32'd1);
    send(3'b010, 8'd10, 8'd20, SAT ? 8'd0 : 8'd246, 1'b1, 1'b1, wt);
    check("throughput_wait", wt, 32'd0);
    send(3'b111, 8'hA5, 8'h0F, 8'hAA, 1'b0, 1'b1, wt);
    check("throughput_wait2", wt, 32'd0);
    send(3'b010, 8'd5, 8'd5, 8'd0, 1'b0, 1'b1, wt);
    send(3'b000, 8'h3C, 8'hFF, 8'hC3, 1'b0, 1'b1, wt);

    // Multiply path (val1<val2).
    send(3'b011, 8'd3, 8'd5, 8'd15, 1'b0, 1'b1, wt);
    wait_result(cyc, rdy);
    check("lat_mul", cyc, 32'd0);
    send(3'b011, 8'd16, 8'd17, SAT ? 8'd255 : 8'd16, 1'b1, 1'b1, wt);

    // Divide path: WIDTH cycles, in_ready low throughout.
    send(3'b011, 8'd20, 8'd20, 8'd1, 1'b0, 1'b1, wt);
    wait_result(cyc, rdy);
    check("div_eq_latency", cyc, W);
    send(3'b011, 8'd100, 8'd7, 8'd14, 1'b0, 1'b1, wt);
    wait_result(cyc, rdy);
    check("div_latency", cyc, W);
    check("div_in_ready_low", {31'd0, rdy}, 32'd0);
    send(3'b011, 8'd9, 8'd0, 8'd9, 1'b0, 1'b1, wt);
    wait_result(cyc, rdy);
    check("div0_latency", cyc, W);

    // Max / equal-sum.
    send(3'b100, 8'd7, 8'd7, 8'd14, 1'b0, 1'b1, wt);
    send(3'b100, 8'd3, 8'd9, 8'd9, 1'b0, 1'b1, wt);
    send(3'b100, 8'd200, 8'd200, SAT ? 8'd255 : 8'd144, 1'b1, 1'b1, wt);

    // Back-pressure: result held, no accept while stalled.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(3'b111, 8'h5A, 8'h0F, 8'h55, 1'b0, 1'b1, wt);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall_valid%0d", k), {31'd0, bus.out_valid}, 32'd1);
      check($sformatf("stall_res%0d", k), {24'd0, bus.res}, 32'h55);
      check($sformatf("stall_in_ready%0d", k), {31'd0, bus.in_ready}, 32'd0);
    end
    bus.out_ready = 1'b1;
    send(3'b001, 8'd50, 8'd30, 8'd80, 1'b0, 1'b1, wt);
    check("drain_accept_same_cycle", wt, 32'd0);

    // Reset in the 4th cycle of a divide: no result may appear.
    @(posedge clk);
    #1;
    send(3'b011, 8'd100, 8'd7, 8'd0, 1'b0, 1'b0, wt);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_mid_div_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_div_in_ready", {31'd0, bus.in_ready}, 32'd1);
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("rst_no_result", seen, 32'd0);
    send(3'b111, 8'hF0, 8'h3C, 8'hCC, 1'b0, 1'b1, wt);
    wait_result(cyc, rdy);
    check("post_rst_latency", cyc, 32'd0);

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
